// File: rtl/exception_sequencer_pkg.sv
// Shared definitions for the exception sequencer: FSM states, cause codes,
// default handler-vector addresses and the cause-to-address lookup.
package exception_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SAVE,
        S_REQ,
        S_WAIT,
        S_LOAD
    } state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE     = 2'b00,
        CAUSE_OPCODE   = 2'b01,
        CAUSE_OVERFLOW = 2'b10,
        CAUSE_DIV0     = 2'b11
    } cause_t;

    localparam logic [31:0] DEF_VEC_OPCODE   = 32'd253;
    localparam logic [31:0] DEF_VEC_OVERFLOW = 32'd254;
    localparam logic [31:0] DEF_VEC_DIV0     = 32'd255;

    function automatic logic [31:0] vec_addr(
        input cause_t      c,
        input logic [31:0] v_opcode,
        input logic [31:0] v_overflow,
        input logic [31:0] v_div0
    );
        logic [31:0] a;
        a = '0;
        case (c)
            CAUSE_OPCODE:   a = v_opcode;
            CAUSE_OVERFLOW: a = v_overflow;
            CAUSE_DIV0:     a = v_div0;
            default:        a = '0;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/exception_sequencer_if.sv
// Handler-vector memory read port: request/address out, data/valid back.
interface exception_sequencer_if;
    logic        mem_rd;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_valid;

    modport master (output mem_rd, mem_addr, input mem_rdata, mem_valid);
    modport slave  (input mem_rd, mem_addr, output mem_rdata, mem_valid);
endinterface

// File: rtl/exception_priority_enc.sv
// Maps the three exception lines to a cause code, opcode > overflow > div0.
module exception_priority_enc
    import exception_sequencer_pkg::*;
(
    input  logic   exc_opcode,
    input  logic   exc_overflow,
    input  logic   exc_div0,
    output cause_t cause,
    output logic   any
);
    always_comb begin
        cause = CAUSE_NONE;
        any   = 1'b1;
        if (exc_opcode)        cause = CAUSE_OPCODE;
        else if (exc_overflow) cause = CAUSE_OVERFLOW;
        else if (exc_div0)     cause = CAUSE_DIV0;
        else                   any   = 1'b0;
    end
endmodule

// File: rtl/exception_sequencer.sv
// Exception entry sequencer: saves EPC, fetches the handler byte from the
// cause's vector address and strobes pc_load once the vector is known.
module exception_sequencer
    import exception_sequencer_pkg::*;
#(
    parameter logic [31:0] VEC_OPCODE   = DEF_VEC_OPCODE,
    parameter logic [31:0] VEC_OVERFLOW = DEF_VEC_OVERFLOW,
    parameter logic [31:0] VEC_DIV0     = DEF_VEC_DIV0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          exc_opcode,
    input  logic                          exc_overflow,
    input  logic                          exc_div0,
    input  logic [31:0]                   pc_in,
    exception_sequencer_if.master         mem,
    output logic [31:0]                   epc_out,
    output logic [31:0]                   vector_out,
    output logic                          pc_load,
    output logic                          busy,
    output logic [1:0]                    exc_cause
);
    state_t      state, state_nxt;
    cause_t      cause_q;
    cause_t      enc_cause;
    logic        enc_any;
    logic        rd;
    logic [31:0] addr;
    logic        unused_rdata_hi;

    exception_priority_enc u_prio (
        .exc_opcode   (exc_opcode),
        .exc_overflow (exc_overflow),
        .exc_div0     (exc_div0),
        .cause        (enc_cause),
        .any          (enc_any)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        rd        = 1'b0;
        addr      = '0;
        pc_load   = 1'b0;
        busy      = 1'b1;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (enc_any) state_nxt = S_SAVE;
            end
            S_SAVE: state_nxt = S_REQ;
            S_REQ: begin
                rd        = 1'b1;
                addr      = vec_addr(cause_q, VEC_OPCODE, VEC_OVERFLOW, VEC_DIV0);
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                rd   = 1'b1;
                addr = vec_addr(cause_q, VEC_OPCODE, VEC_OVERFLOW, VEC_DIV0);
                if (mem.mem_valid) state_nxt = S_LOAD;
            end
            S_LOAD: begin
                pc_load   = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Captured registers; exception lines and mem_valid only matter in their own state.
    always_ff @(posedge clk) begin
        if (reset) begin
            epc_out    <= '0;
            vector_out <= '0;
            cause_q    <= CAUSE_NONE;
        end else begin
            case (state)
                S_IDLE: if (enc_any) cause_q <= enc_cause;
                S_SAVE: epc_out <= pc_in - 32'd4;
                S_WAIT: if (mem.mem_valid) vector_out <= {24'b0, mem.mem_rdata[7:0]};
                default: ;
            endcase
        end
    end

    assign mem.mem_rd    = rd;
    assign mem.mem_addr  = addr;
    assign exc_cause     = cause_q;
    assign unused_rdata_hi = ^mem.mem_rdata[31:8];
endmodule
